// File: rtl/audio_pkg.sv
// audio_pkg: constants shared by the sample feeder and the PWM output block
package audio_pkg;
    localparam int SAMPLE_W = 8;
    localparam int FRAME_LEN_DEFAULT = 256;
    localparam logic [SAMPLE_W-1:0] MIDSCALE = 8'h80;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: small synchronous FIFO; a push while full is ignored unless a pop happens in the same cycle
module sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = SAMPLE_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i & ~empty_q;
    assign do_push = push_i & (~full_q | do_pop);
    assign count_d = count_q + CW'(do_push) - CW'(do_pop);
    assign dout_o  = mem_q[rd_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;

    // storage array, written on every accepted push
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    // pointers, occupancy and the registered full/empty flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= do_push ? wr_q + 1'b1 : wr_q;
            rd_q    <= do_pop ? rd_q + 1'b1 : rd_q;
            count_q <= count_d;
            full_q  <= count_d == CW'(DEPTH);
            empty_q <= count_d == '0;
        end
    end
endmodule

// File: rtl/sample_feeder.sv
// sample_feeder: SPI byte receiver feeding one sample per PWM frame; SAMPLE_FEEDER_MIDSCALE_ON_UNDERFLOW_EN outputs midscale on underflow
module sample_feeder
    import audio_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int FRAME_LEN = FRAME_LEN_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                spi_sclk,
    input  logic                spi_mosi,
    input  logic                spi_cs_n,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                frame_tick,
    output logic                fifo_full,
    output logic                fifo_empty,
    output logic                overflow,
    output logic                underflow
);
    localparam int FW = $clog2(FRAME_LEN);

    logic [2:0]          sclk_q;
    logic [1:0]          mosi_q, cs_q;
    logic [SAMPLE_W-2:0] shift_q, shift_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [FW-1:0]       frame_q, frame_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d, under_val, fifo_dout;
    logic                tick_q, ovf_q, ovf_d, unf_q, unf_d;
    logic                sclk_rise, push, pop, boundary, full_w;
    logic [$clog2(DEPTH):0] level;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign boundary  = frame_q == FW'(FRAME_LEN - 1);
    assign pop       = boundary & (level != '0);

`ifdef SAMPLE_FEEDER_MIDSCALE_ON_UNDERFLOW_EN
    assign under_val = MIDSCALE;
`else
    assign under_val = sample_q;
`endif

    // shift in one bit per synced sclk rise while selected; deselect drops any partial byte
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        push      = 1'b0;
        if (cs_q[1]) begin
            bit_cnt_d = '0;
        end else if (sclk_rise) begin
            shift_d   = {shift_q[SAMPLE_W-3:0], mosi_q[1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            push      = bit_cnt_q == 3'd7;
        end
    end

    // frame timer, output sample selection and sticky error flags
    always_comb begin
        frame_d  = boundary ? '0 : frame_q + 1'b1;
        sample_d = pop ? fifo_dout : boundary ? under_val : sample_q;
        ovf_d    = ovf_q | (push & full_w & ~pop);
        unf_d    = unf_q | (boundary & ~pop);
    end

    // synchronizers and all datapath state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q    <= '0;
            mosi_q    <= '0;
            cs_q      <= 2'b11;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            frame_q   <= '0;
            sample_q  <= '0;
            tick_q    <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            sclk_q    <= {sclk_q[1:0], spi_sclk};
            mosi_q    <= {mosi_q[0], spi_mosi};
            cs_q      <= {cs_q[0], spi_cs_n};
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            sample_q  <= sample_d;
            tick_q    <= boundary;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    sample_fifo #(.DEPTH(DEPTH), .WIDTH(SAMPLE_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({shift_q, mosi_q[1]}),
        .dout_o  (fifo_dout),
        .full_o  (full_w),
        .empty_o (fifo_empty),
        .count_o (level)
    );

    assign fifo_full  = full_w;
    assign sample_out = sample_q;
    assign frame_tick = tick_q;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;
endmodule
